// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/data memory port arbiter.
// Imported by the arbiter top and its latency timer.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  // Wide enough for MEM_LAT up to 7 and STARVE_MAX up to 15.
  localparam int CNT_W    = 3;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_lat_timer.sv
// Fixed-latency countdown: loaded on each grant, done when it has run out.
// Stays at zero when idle so done is also high outside a transaction.
module mem_lat_timer #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  output logic done
);
  import mem_port_arbiter_pkg::*;

  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(MEM_LAT - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory shared by instruction fetch and data access: one
// transaction in flight, data priority with an IF starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  input  logic [DATA_W/8-1:0]   dm_be,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_rdata
);
  import mem_port_arbiter_pkg::*;

  state_t               state, state_nxt;
  owner_t               owner, owner_nxt;
  logic                 wr_q, wr_nxt;
  logic [STARVE_W-1:0]  starve_cnt, starve_nxt;
  logic                 done, resp, free, grant_if, grant_dm, grant;

  mem_lat_timer #(.MEM_LAT(MEM_LAT)) u_timer (
    .clk  (clk),
    .rstn (rstn),
    .load (grant),
    .done (done)
  );

  // Free in IDLE or in the response cycle; gated by rstn so no grant leaks out during reset.
  always_comb begin
    resp     = (state == ST_BUSY) && done;
    free     = rstn && ((state == ST_IDLE) || resp);
    grant_if = free && if_req && (!dm_req || (starve_cnt == STARVE_W'(STARVE_MAX)));
    grant_dm = free && dm_req && !grant_if;
    grant    = grant_if || grant_dm;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (grant_if) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
      mem_be   = '1;
    end else if (grant_dm) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_be    = dm_be;
    end
  end

  always_comb begin
    if_gnt    = grant_if;
    dm_gnt    = grant_dm;
    if_rvalid = resp && (owner == OWN_IF);
    dm_rvalid = resp && (owner == OWN_DM);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = (dm_rvalid && !wr_q) ? mem_rdata : '0;
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    wr_nxt     = wr_q;
    starve_nxt = starve_cnt;
    if (grant) begin
      state_nxt = ST_BUSY;
      owner_nxt = grant_if ? OWN_IF : OWN_DM;
      wr_nxt    = grant_dm && dm_we;
    end else if (resp) begin
      state_nxt = ST_IDLE;
      owner_nxt = OWN_NONE;
      wr_nxt    = 1'b0;
    end
    // A data win only counts against IF while IF is actually waiting.
    if (!if_req || grant_if) begin
      starve_nxt = '0;
    end else if (grant_dm && (starve_cnt != STARVE_W'(STARVE_MAX))) begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      owner      <= OWN_NONE;
      wr_q       <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      wr_q       <= wr_nxt;
      starve_cnt <= starve_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model (due-cycle bookkeeping and a reference memory).
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
  localparam int SM1        = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        if_req = 1'b0, if_gnt, if_rvalid;
  logic [31:0] if_addr = '0, if_rdata;
  logic        dm_req = 1'b0, dm_we = 1'b0, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr = '0, dm_wdata = '0, dm_rdata;
  logic [3:0]  dm_be = '0;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be;

  // Second instance: MEM_LAT=1 with both ports always requesting.
  logic        both1 = 1'b0;
  logic        if_gnt1, if_rvalid1, dm_gnt1, dm_rvalid1, mem_en1, mem_we1;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1 = '0;
  logic [3:0]  mem_be1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) u_dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1), .STARVE_MAX(SM1)) u_dut1 (
    .clk(clk), .rstn(rstn),
    .if_req(both1), .if_addr(32'h100), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .dm_req(both1), .dm_we(1'b0), .dm_addr(32'h200), .dm_wdata(32'h0), .dm_be(4'h0),
    .dm_gnt(dm_gnt1), .dm_rvalid(dm_rvalid1), .dm_rdata(dm_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_be(mem_be1),
    .mem_rdata(mem_rdata1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  function automatic logic any_out0();
    return |{if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, mem_be};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory attached to the DUT: commands captured mid-cycle, read data presented MEM_LAT cycles on.
  logic [31:0] mem_arr [256];
  bit          mem_wr  [256];
  int          mem_due = -1;
  logic [31:0] mem_pend = '0, m1_data = '0;

  initial begin : memory
    int idx;
    logic [31:0] cur;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        idx = int'(mem_addr[9:2]);
        cur = mem_wr[idx] ? mem_arr[idx] : init_word(idx);
        mem_pend = cur;
        if (mem_we) begin
          for (int b = 0; b < 4; b++) if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
          mem_arr[idx] = cur;
          mem_wr[idx]  = 1'b1;
        end
        mem_due = cyc + MEM_LAT;
      end
      if (mem_en1) m1_data = mem_addr1;
    end
  end

  initial begin : memory_out
    forever begin
      @(posedge clk);
      #1;
      mem_rdata  = (mem_due == cyc) ? mem_pend : $urandom;
      mem_rdata1 = m1_data;
    end
  end

  // Transaction-level model: one outstanding access, its due cycle, and a reference memory.
  initial begin : model
    bit          m_valid, m_is_if, resp_now, free, e_if, e_dm;
    int          m_due, m_starve, idx;
    logic [31:0] m_data, cur;
    logic [31:0] ref_mem [256];
    bit          ref_wr  [256];
    m_valid = 0; m_starve = 0; m_due = 0; m_is_if = 0; m_data = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        check("reset_outputs_zero", 32'(any_out0()), 32'h0);
        m_valid  = 0;
        m_starve = 0;
      end else begin
        resp_now = m_valid && (m_due == cyc);
        free     = !m_valid || resp_now;
        e_if     = free && if_req && (!dm_req || m_starve == STARVE_MAX);
        e_dm     = free && dm_req && !e_if;
        check("if_gnt", 32'(if_gnt), 32'(e_if));
        check("dm_gnt", 32'(dm_gnt), 32'(e_dm));
        check("mem_en", 32'(mem_en), 32'(e_if || e_dm));
        if (e_if) begin
          check("if_mem_we", 32'(mem_we), 32'h0);
          check("if_mem_addr", mem_addr, if_addr);
          check("if_mem_be", 32'(mem_be), 32'hF);
        end else if (e_dm) begin
          check("dm_mem_we", 32'(mem_we), 32'(dm_we));
          check("dm_mem_addr", mem_addr, dm_addr);
          if (dm_we) begin
            check("dm_mem_wdata", mem_wdata, dm_wdata);
            check("dm_mem_be", 32'(mem_be), 32'(dm_be));
          end
        end else begin
          check("idle_mem_cmd_zero", 32'(|{mem_we, mem_addr, mem_wdata, mem_be}), 32'h0);
        end
        check("if_rvalid", 32'(if_rvalid), 32'(resp_now && m_is_if));
        check("dm_rvalid", 32'(dm_rvalid), 32'(resp_now && !m_is_if));
        check("if_rdata", if_rdata, (resp_now && m_is_if) ? m_data : 32'h0);
        check("dm_rdata", dm_rdata, (resp_now && !m_is_if) ? m_data : 32'h0);

        if (resp_now) m_valid = 0;
        if (!if_req || e_if) m_starve = 0;
        else if (e_dm && m_starve < STARVE_MAX) m_starve++;
        if (e_if || e_dm) begin
          m_valid = 1;
          m_due   = cyc + MEM_LAT;
          m_is_if = e_if;
          idx = e_if ? int'(if_addr[9:2]) : int'(dm_addr[9:2]);
          cur = ref_wr[idx] ? ref_mem[idx] : init_word(idx);
          if (e_dm && dm_we) begin
            for (int b = 0; b < 4; b++) if (dm_be[b]) cur[8*b +: 8] = dm_wdata[8*b +: 8];
            ref_mem[idx] = cur;
            ref_wr[idx]  = 1'b1;
            m_data = 32'h0;
          end else begin
            m_data = cur;
          end
        end
      end
    end
  end

  // Requesters must hold req and command steady until granted.
  initial begin : protocol
    logic p_rst, p_if, p_ifg, p_dm, p_dmg, p_we;
    logic [31:0] p_ia, p_da, p_dw;
    logic [3:0] p_be;
    p_rst = 0; p_if = 0; p_ifg = 0; p_dm = 0; p_dmg = 0; p_we = 0;
    p_ia = '0; p_da = '0; p_dw = '0; p_be = '0;
    forever begin
      @(negedge clk);
      if (rstn && p_rst) begin
        if (p_if && !p_ifg)
          assert (if_req && if_addr == p_ia) else $error("IF request dropped or changed before grant");
        if (p_dm && !p_dmg)
          assert (dm_req && dm_we == p_we && dm_addr == p_da && (!p_we || (dm_wdata == p_dw && dm_be == p_be)))
            else $error("DM request dropped or changed before grant");
      end
      p_rst = rstn; p_if = if_req; p_ifg = if_gnt; p_dm = dm_req; p_dmg = dm_gnt;
      p_ia = if_addr; p_we = dm_we; p_da = dm_addr; p_dw = dm_wdata; p_be = dm_be;
    end
  end

  task automatic wait_if_and_drop(string name);
    bit g = 0;
    for (int c = 0; c < 20 && !g; c++) begin
      @(negedge clk);
      g = if_gnt;
      step();
    end
    check(name, 32'(g), 32'h1);
    if_req = 1'b0;
  endtask

  task automatic wait_dm_and_drop(string name);
    bit g = 0;
    for (int c = 0; c < 20 && !g; c++) begin
      @(negedge clk);
      g = dm_gnt;
      step();
    end
    check(name, 32'(g), 32'h1);
    dm_req = 1'b0;
  endtask

  initial begin : stimulus
    int n_dm, n_if1;
    bit got_if, ig, dg;

    repeat (2) @(negedge clk);
    check("reset_mem_en", 32'(mem_en), 32'h0);
    step();
    rstn = 1'b1;

    // IF-only fetch in the first cycle after reset release.
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("b_if_gnt", 32'(if_gnt), 32'h1);
    check("b_mem_addr", mem_addr, 32'h10);
    step(); if_req = 1'b0;
    step();
    @(negedge clk);
    check("b_if_rvalid", 32'(if_rvalid), 32'h1);
    check("b_if_rdata", if_rdata, 32'hA5A5_0004);

    // Simultaneous requests: data first, fetch on the response cycle.
    step();
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    @(negedge clk);
    check("c_dm_gnt", 32'(dm_gnt), 32'h1);
    check("c_if_wait", 32'(if_gnt), 32'h0);
    step(); dm_req = 1'b0;
    step();
    @(negedge clk);
    check("c_dm_rdata", dm_rdata, 32'hA5A5_0040);
    check("c_if_gnt", 32'(if_gnt), 32'h1);
    step(); if_req = 1'b0;
    step();
    @(negedge clk);
    check("c_if_rdata", if_rdata, 32'hA5A5_0008);

    // Byte-masked write then read-back.
    step();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
    @(negedge clk);
    check("d_mem_we", 32'(mem_we), 32'h1);
    check("d_mem_be", 32'(mem_be), 32'h3);
    step(); dm_req = 1'b0; dm_we = 1'b0;
    step();
    @(negedge clk);
    check("d_wr_rvalid", 32'(dm_rvalid), 32'h1);
    check("d_wr_rdata", dm_rdata, 32'h0);
    step();
    dm_req = 1'b1; dm_addr = 32'h200;
    step(); dm_req = 1'b0;
    step();
    @(negedge clk);
    check("d_readback", dm_rdata, 32'hA5A5_BEEF);

    // Starvation guard: IF waits through STARVE_MAX data wins, then wins.
    step();
    if_req = 1'b1; if_addr = 32'h30;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    n_dm = 0; got_if = 0;
    for (int c = 0; c < 40 && !got_if; c++) begin
      @(negedge clk);
      if (dm_gnt) n_dm++;
      got_if = if_gnt;
      step();
    end
    if_req = 1'b0;
    check("e_if_granted", 32'(got_if), 32'h1);
    check("e_dm_wins", 32'(n_dm), 32'(STARVE_MAX));
    wait_dm_and_drop("e_dm_drain");
    repeat (3) step();

    // Reset one cycle after a data grant.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
    @(negedge clk);
    check("f_dm_gnt", 32'(dm_gnt), 32'h1);
    step();
    dm_req = 1'b0; rstn = 1'b0; if_req = 1'b1; if_addr = 32'h14;
    #1;
    check("f_outs_zero", 32'(any_out0()), 32'h0);
    step();
    rstn = 1'b1;
    @(negedge clk);
    check("f_if_gnt_after_rst", 32'(if_gnt), 32'h1);
    check("f_no_stale_rvalid", 32'(dm_rvalid), 32'h0);
    step(); if_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("f_no_dm_rvalid", 32'(dm_rvalid), 32'h0);
      step();
    end

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ig = if_gnt; dg = dm_gnt;
      step();
      if (ig) if_req = 1'b0;
      if (dg) dm_req = 1'b0;
      if (!if_req && $urandom_range(0, 99) < 50) begin
        if_req  = 1'b1;
        if_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!dm_req && $urandom_range(0, 99) < 50) begin
        dm_req   = 1'b1;
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = 32'($urandom_range(0, 15)) << 2;
        dm_wdata = $urandom;
        dm_be    = 4'($urandom_range(0, 15));
      end
    end
    if (if_req) wait_if_and_drop("g_if_drain");
    if (dm_req) wait_dm_and_drop("g_dm_drain");
    repeat (3) step();

    // MEM_LAT=1: a grant every cycle, IF wins one arbitration in SM1+1.
    both1 = 1'b1;
    n_if1 = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (if_gnt1) n_if1++;
      check("h_if_gnt", 32'(if_gnt1), 32'((c % 3) == 2));
      check("h_dm_gnt", 32'(dm_gnt1), 32'((c % 3) != 2));
      check("h_if_rvalid", 32'(if_rvalid1), 32'(c >= 1 && ((c - 1) % 3) == 2));
      check("h_dm_rvalid", 32'(dm_rvalid1), 32'(c >= 1 && ((c - 1) % 3) != 2));
      if (c >= 1 && ((c - 1) % 3) != 2) check("h_dm_rdata", dm_rdata1, 32'h200);
      step();
    end
    both1 = 1'b0;
    check("h_if_share", 32'(n_if1), 32'd10);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
